// File: rtl/quad_step_decoder_if.sv
// Quadrature decoder bus: encoder inputs, enable, and the step/direction/error outputs.
interface quad_step_decoder_if #(
  parameter int unsigned ERR_CNT_W = 8
);
  logic                 enable;
  logic                 a_in;
  logic                 b_in;
  logic                 step;
  logic                 up_down;
  logic                 err;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output enable, a_in, b_in,
    input  step, up_down, err, err_cnt
  );

  modport slave (
    input  enable, a_in, b_in,
    output step, up_down, err, err_cnt
  );
endinterface

// File: rtl/quad_step_decoder.sv
// Quadrature encoder front end: 2-flop synchronisers, per-channel glitch filters,
// Gray-code transition decoder and a saturating illegal-transition counter.
// Optional macro QDEC_X1_MODE_EN selects x1 decoding (one step per encoder cycle);
// undefined gives x4 decoding.
module quad_step_decoder #(
  parameter int unsigned FILT_LEN  = 3,
  parameter int unsigned ERR_CNT_W = 8
) (
  input logic                clk,
  input logic                reset,
  quad_step_decoder_if.slave bus
);

  localparam logic [3:0] FILT_CNT = 4'(FILT_LEN);

  typedef enum logic [1:0] {PRIME0, PRIME1, PRIME2, RUN} state_t;

  state_t               r_state;
  logic [1:0]           r_sync_a;
  logic [1:0]           r_sync_b;
  logic [3:0]           r_cnt_a;
  logic [3:0]           r_cnt_b;
  logic                 r_filt_a;
  logic                 r_filt_b;
  logic [1:0]           r_prev;
  logic                 r_step;
  logic                 r_up_down;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  logic                 w_primed;
  logic [1:0]           w_cur;
  logic [1:0]           w_fwd_next;
  logic [1:0]           w_rev_next;
  logic                 w_cnt_up;
  logic                 w_cnt_dn;
  logic                 w_illegal;

  assign w_primed = (r_state == RUN);
  assign w_cur    = {r_filt_a, r_filt_b};

  // Two-flop synchronisers; bit 1 is the synchronised (sync2) value
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync_a <= '0;
      r_sync_b <= '0;
    end else begin
      r_sync_a <= {r_sync_a[0], bus.a_in};
      r_sync_b <= {r_sync_b[0], bus.b_in};
    end
  end

  // Priming sequencer: three clocks of direct loading after reset release
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= PRIME0;
    end else begin
      unique case (r_state)
        PRIME0:  r_state <= PRIME1;
        PRIME1:  r_state <= PRIME2;
        PRIME2:  r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  // Channel A glitch filter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_a  <= '0;
      r_filt_a <= 1'b0;
    end else if (!w_primed) begin
      r_cnt_a  <= '0;
      r_filt_a <= r_sync_a[1];
    end else if (r_sync_a[1] == r_filt_a) begin
      r_cnt_a  <= '0;
    end else if (r_cnt_a == FILT_CNT) begin
      r_cnt_a  <= '0;
      r_filt_a <= r_sync_a[1];
    end else begin
      r_cnt_a  <= r_cnt_a + 4'd1;
    end
  end

  // Channel B glitch filter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt_b  <= '0;
      r_filt_b <= 1'b0;
    end else if (!w_primed) begin
      r_cnt_b  <= '0;
      r_filt_b <= r_sync_b[1];
    end else if (r_sync_b[1] == r_filt_b) begin
      r_cnt_b  <= '0;
    end else if (r_cnt_b == FILT_CNT) begin
      r_cnt_b  <= '0;
      r_filt_b <= r_sync_b[1];
    end else begin
      r_cnt_b  <= r_cnt_b + 4'd1;
    end
  end

  // Gray-code classification of the filtered state against the previous one
  always_comb begin
    w_fwd_next = 2'b00;
    w_rev_next = 2'b00;
    unique case (r_prev)
      2'b00: begin w_fwd_next = 2'b01; w_rev_next = 2'b10; end
      2'b01: begin w_fwd_next = 2'b11; w_rev_next = 2'b00; end
      2'b11: begin w_fwd_next = 2'b10; w_rev_next = 2'b01; end
      default: begin w_fwd_next = 2'b00; w_rev_next = 2'b11; end
    endcase
    w_illegal = (w_cur == ~r_prev);
`ifdef QDEC_X1_MODE_EN
    w_cnt_up  = (w_cur == w_fwd_next) && (r_prev == 2'b10);
    w_cnt_dn  = (w_cur == w_rev_next) && (r_prev == 2'b00);
`else
    w_cnt_up  = (w_cur == w_fwd_next);
    w_cnt_dn  = (w_cur == w_rev_next);
`endif
  end

  // Registered decoder outputs; prev tracks even while disabled so stale edges are consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prev    <= '0;
      r_step    <= 1'b0;
      r_err     <= 1'b0;
      r_up_down <= 1'b1;
      r_err_cnt <= '0;
    end else begin
      r_step <= 1'b0;
      r_err  <= 1'b0;
      if (!w_primed) begin
        r_prev <= {r_sync_a[1], r_sync_b[1]};
      end else begin
        r_prev <= w_cur;
        if (bus.enable) begin
          if (w_cnt_up) begin
            r_step    <= 1'b1;
            r_up_down <= 1'b1;
          end else if (w_cnt_dn) begin
            r_step    <= 1'b1;
            r_up_down <= 1'b0;
          end else if (w_illegal) begin
            r_err <= 1'b1;
            if (r_err_cnt != '1) begin
              r_err_cnt <= r_err_cnt + 1'b1;
            end
          end
        end
      end
    end
  end

  assign bus.step    = r_step;
  assign bus.up_down = r_up_down;
  assign bus.err     = r_err;
  assign bus.err_cnt = r_err_cnt;

endmodule

// File: tb/tb_quad_step_decoder.sv
// Directed bench for quad_step_decoder (default x4 build, FILT_LEN=3).
// A second instance with ERR_CNT_W=2 shares the stimulus to exercise saturation.
module tb_quad_step_decoder;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  quad_step_decoder_if #(.ERR_CNT_W(8)) bus ();
  quad_step_decoder_if #(.ERR_CNT_W(2)) bus2 ();

  assign bus2.enable = bus.enable;
  assign bus2.a_in   = bus.a_in;
  assign bus2.b_in   = bus.b_in;

  quad_step_decoder #(.FILT_LEN(3), .ERR_CNT_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  quad_step_decoder #(.FILT_LEN(3), .ERR_CNT_W(2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  int unsigned n_cmp  = 0;
  int unsigned n_bad  = 0;
  int unsigned n_both = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold AB for n clocks, counting step pulses, err pulses and up-steps
  task automatic drive(input logic [1:0] ab, input int unsigned n,
                       output int unsigned ns, output int unsigned ne, output int unsigned nu);
    bus.a_in = ab[1];
    bus.b_in = ab[0];
    ns = 0; ne = 0; nu = 0;
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      if (bus.step === 1'b1) ns++;
      if (bus.err === 1'b1) ne++;
      if (bus.step === 1'b1 && bus.up_down === 1'b1) nu++;
      if (bus.step === 1'b1 && bus.err === 1'b1) n_both++;
    end
  endtask

  task automatic do_reset(input logic [1:0] ab);
    int unsigned ns, ne, nu;
    bus.enable = 1'b1;
    bus.a_in = ab[1];
    bus.b_in = ab[0];
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    drive(ab, 8, ns, ne, nu);
  endtask

  task automatic test_reset();
    int unsigned ns, ne, nu;
    bus.enable = 1'b1;
    bus.a_in = 1'b0;
    bus.b_in = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    n_cmp++; if (bus.step !== 1'b0) begin n_bad++; $display("FAIL rst_step: got %b expected 0", bus.step); end
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL rst_err: got %b expected 0", bus.err); end
    n_cmp++; if (bus.up_down !== 1'b1) begin n_bad++; $display("FAIL rst_updown: got %b expected 1", bus.up_down); end
    n_cmp++; if (bus.err_cnt !== 8'd0) begin n_bad++; $display("FAIL rst_errcnt: got %0d expected 0", bus.err_cnt); end
    n_cmp++; if (bus2.err_cnt !== 2'd0) begin n_bad++; $display("FAIL rst_errcnt2: got %0d expected 0", bus2.err_cnt); end
    reset = 1'b0;
    drive(2'b00, 8, ns, ne, nu);
    n_cmp++; if (ns + ne != 0) begin n_bad++; $display("FAIL rst_idle_pulses: got %0d expected 0", ns + ne); end
  endtask

  task automatic test_forward();
    int unsigned ns, ne, nu, ts, te, tu;
    do_reset(2'b00);
    drive(2'b01, 6, ns, ne, nu);
    n_cmp++; if (ns != 0) begin n_bad++; $display("FAIL fwd_early_step: got %0d expected 0", ns); end
    tick();
    n_cmp++; if (bus.step !== 1'b1 || bus.up_down !== 1'b1) begin
      n_bad++; $display("FAIL fwd_latency: got step=%b up=%b expected step=1 up=1", bus.step, bus.up_down); end
    ts = 0; te = 0; tu = 0;
    drive(2'b01, 3, ns, ne, nu);  ts += ns; te += ne; tu += nu;
    drive(2'b11, 10, ns, ne, nu); ts += ns; te += ne; tu += nu;
    drive(2'b10, 10, ns, ne, nu); ts += ns; te += ne; tu += nu;
    drive(2'b00, 10, ns, ne, nu); ts += ns; te += ne; tu += nu;
    n_cmp++; if (ts != 3 || tu != 3) begin n_bad++; $display("FAIL fwd_steps: got %0d (up %0d) expected 3 (up 3)", ts, tu); end
    n_cmp++; if (te != 0) begin n_bad++; $display("FAIL fwd_err: got %0d expected 0", te); end
  endtask

  task automatic test_reverse();
    int unsigned ns, ne, nu, ts, te, tu;
    logic [3:0] cnt;
    logic [1:0] seq [4];
    seq[0] = 2'b10; seq[1] = 2'b11; seq[2] = 2'b01; seq[3] = 2'b00;
    do_reset(2'b00);
    cnt = 4'h0; ts = 0; te = 0; tu = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      drive(seq[i], 10, ns, ne, nu);
      ts += ns; te += ne; tu += nu;
      cnt = cnt + 4'(nu) - 4'(ns - nu);
    end
    n_cmp++; if (ts != 4 || tu != 0) begin n_bad++; $display("FAIL rev_steps: got %0d (up %0d) expected 4 (up 0)", ts, tu); end
    n_cmp++; if (bus.up_down !== 1'b0) begin n_bad++; $display("FAIL rev_updown: got %b expected 0", bus.up_down); end
    n_cmp++; if (cnt !== 4'hC) begin n_bad++; $display("FAIL rev_counter: got %h expected c", cnt); end
    n_cmp++; if (te != 0) begin n_bad++; $display("FAIL rev_err: got %0d expected 0", te); end
  endtask

  task automatic test_glitch();
    int unsigned ns, ne, nu, ts, te;
    do_reset(2'b00);
    ts = 0; te = 0;
    drive(2'b10, 2, ns, ne, nu);  ts += ns; te += ne;
    drive(2'b00, 12, ns, ne, nu); ts += ns; te += ne;
    n_cmp++; if (ts != 0 || te != 0) begin n_bad++; $display("FAIL glitch_short: got steps=%0d errs=%0d expected 0/0", ts, te); end
    // 4-clock pulse: rising edge counted at +6, falling edge (reverse back) counted at +10
    ts = 0;
    drive(2'b10, 4, ns, ne, nu); ts += ns;
    drive(2'b00, 3, ns, ne, nu); ts += ns;
    n_cmp++; if (ts != 1 || bus.up_down !== 1'b0) begin
      n_bad++; $display("FAIL glitch_long: got steps=%0d up=%b expected 1/0", ts, bus.up_down); end
    drive(2'b00, 10, ns, ne, nu);
    n_cmp++; if (ns != 1 || nu != 1) begin n_bad++; $display("FAIL glitch_return: got steps=%0d up=%0d expected 1/1", ns, nu); end
  endtask

  task automatic test_illegal();
    int unsigned ns, ne, nu, te;
    do_reset(2'b00);
    drive(2'b10, 10, ns, ne, nu);
    n_cmp++; if (ns != 1 || nu != 0) begin n_bad++; $display("FAIL ill_setup: got steps=%0d up=%0d expected 1/0", ns, nu); end
    drive(2'b01, 10, ns, ne, nu);
    n_cmp++; if (ne != 1) begin n_bad++; $display("FAIL ill_err_pulse: got %0d expected 1", ne); end
    n_cmp++; if (ns != 0) begin n_bad++; $display("FAIL ill_step: got %0d expected 0", ns); end
    n_cmp++; if (bus.up_down !== 1'b0) begin n_bad++; $display("FAIL ill_updown: got %b expected 0", bus.up_down); end
    n_cmp++; if (bus.err_cnt !== 8'd1) begin n_bad++; $display("FAIL ill_errcnt1: got %0d expected 1", bus.err_cnt); end
    te = 0;
    for (int unsigned i = 0; i < 4; i++) begin
      drive((i % 2 == 0) ? 2'b10 : 2'b01, 10, ns, ne, nu);
      te += ne;
    end
    n_cmp++; if (te != 4) begin n_bad++; $display("FAIL ill_more: got %0d expected 4", te); end
    n_cmp++; if (bus.err_cnt !== 8'd5) begin n_bad++; $display("FAIL ill_errcnt5: got %0d expected 5", bus.err_cnt); end
    n_cmp++; if (bus2.err_cnt !== 2'd3) begin n_bad++; $display("FAIL ill_saturate: got %0d expected 3", bus2.err_cnt); end
  endtask

  task automatic test_enable();
    int unsigned ns, ne, nu;
    do_reset(2'b00);
    bus.enable = 1'b0;
    drive(2'b01, 10, ns, ne, nu);
    n_cmp++; if (ns != 0) begin n_bad++; $display("FAIL en_disabled_step: got %0d expected 0", ns); end
    bus.enable = 1'b1;
    drive(2'b01, 5, ns, ne, nu);
    n_cmp++; if (ns != 0) begin n_bad++; $display("FAIL en_replay: got %0d expected 0", ns); end
    drive(2'b11, 10, ns, ne, nu);
    n_cmp++; if (ns != 1 || nu != 1) begin n_bad++; $display("FAIL en_reenabled: got steps=%0d up=%0d expected 1/1", ns, nu); end
  endtask

  task automatic test_prime_high();
    int unsigned ns, ne, nu;
    bus.enable = 1'b1;
    bus.a_in = 1'b1;
    bus.b_in = 1'b1;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    drive(2'b11, 12, ns, ne, nu);
    n_cmp++; if (ns != 0 || ne != 0) begin n_bad++; $display("FAIL prime_high: got steps=%0d errs=%0d expected 0/0", ns, ne); end
    drive(2'b10, 10, ns, ne, nu);
    n_cmp++; if (ns != 1 || nu != 1) begin n_bad++; $display("FAIL prime_first: got steps=%0d up=%0d expected 1/1", ns, nu); end
  endtask

  task automatic test_reset_mid();
    int unsigned ns, ne, nu;
    do_reset(2'b00);
    drive(2'b11, 10, ns, ne, nu);
    drive(2'b01, 10, ns, ne, nu);
    n_cmp++; if (bus.err_cnt !== 8'd1 || bus.up_down !== 1'b0) begin
      n_bad++; $display("FAIL mid_setup: got errcnt=%0d up=%b expected 1/0", bus.err_cnt, bus.up_down); end
    drive(2'b00, 3, ns, ne, nu);
    reset = 1'b1;
    tick();
    n_cmp++; if (bus.step !== 1'b0 || bus.err !== 1'b0) begin
      n_bad++; $display("FAIL mid_pulses: got step=%b err=%b expected 0/0", bus.step, bus.err); end
    n_cmp++; if (bus.err_cnt !== 8'd0) begin n_bad++; $display("FAIL mid_errcnt: got %0d expected 0", bus.err_cnt); end
    n_cmp++; if (bus.up_down !== 1'b1) begin n_bad++; $display("FAIL mid_updown: got %b expected 1", bus.up_down); end
    reset = 1'b0;
    drive(2'b00, 3, ns, ne, nu);
    n_cmp++; if (ns != 0 || ne != 0) begin n_bad++; $display("FAIL mid_prime: got steps=%0d errs=%0d expected 0/0", ns, ne); end
    drive(2'b00, 5, ns, ne, nu);
    drive(2'b01, 10, ns, ne, nu);
    n_cmp++; if (ns != 1 || nu != 1) begin n_bad++; $display("FAIL mid_resume: got steps=%0d up=%0d expected 1/1", ns, nu); end
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.a_in = 1'b0;
    bus.b_in = 1'b0;
    test_reset();
    test_forward();
    test_reverse();
    test_glitch();
    test_illegal();
    test_enable();
    test_prime_high();
    test_reset_mid();
    n_cmp++; if (n_both != 0) begin n_bad++; $display("FAIL step_err_overlap: got %0d expected 0", n_both); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/quad_step_decoder.md
Name: quad_step_decoder

Overview:
- Upstream stage for the parameterised up/down counter. Turns a raw two-channel quadrature encoder signal (A/B) into a one-cycle count strobe and a direction level.
- step drives the counter's count enable; up_down drives the counter's direction input (1 = up).
- Contains input synchronisers, per-channel glitch filters, a Gray-code transition decoder and a saturating illegal-transition counter.

Parameters:
- FILT_LEN, 3, consecutive stable clocks a synchronised channel must differ from its filtered value before the filtered value updates (legal range 1..15).
- ERR_CNT_W, 8, width of the saturating illegal-transition counter.

Ports:
- clk  input  1  system clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- enable  input  1  1 = step and err may pulse; 0 = outputs frozen, front end keeps tracking
- a_in  input  1  raw encoder channel A, asynchronous
- b_in  input  1  raw encoder channel B, asynchronous
- step  output  1  one-clock pulse per counted transition
- up_down  output  1  direction of the last counted transition, 1 = up
- err  output  1  one-clock pulse on an illegal (double-bit) transition
- err_cnt  output  ERR_CNT_W  saturating count of err pulses

Behaviour:
- Reset (reset=1 at a clk edge) clears the following:
  - sync flops, filter counters, filtered A/B and prev-state register to 0
  - the priming counter
  - step=0, err=0, err_cnt=0, up_down=1
- Synchroniser: two flops per channel, giving sync2.
- Priming after reset release:
  - For the first 3 clocks, filtered A/B and prev load sync2 directly.
  - No step or err is generated during priming.
  - primed sets on the 3rd clock. This prevents a spurious step/err when the encoder rests at a non-00 state.
- Filter, per channel:
  - The counter increments while sync2 != filtered and clears when they are equal.
  - When the count reaches FILT_LEN, filtered takes sync2 and the counter clears.
  - A pulse shorter than FILT_LEN clocks after synchronisation never reaches filtered.
- Decoder, comparing {fA,fB} with prev each clock once primed:
  - Forward Gray order: 00->01->11->10->00. Any forward step sets step=1 and up_down=1.
  - Reverse order: 00->10->11->01->00. Any reverse step sets step=1 and up_down=0.
  - Both bits changed in the same clock (00<->11, 01<->10) sets err=1. No step; up_down holds.
  - No change: step=0, err=0.
  - prev always updates to {fA,fB}, including after an illegal transition.
- Latency: a level change on a_in/b_in that is first sampled at edge k produces step at edge k+FILT_LEN+3.
- enable=0:
  - Synchroniser, filter and prev keep running.
  - step and err are forced to 0; up_down and err_cnt hold.
  - Transitions seen while disabled are consumed, not replayed when enable returns.
- err_cnt increments on every err pulse and saturates at all-ones (no wrap).
- step and err are registered outputs and are never high in the same cycle.
- Reset asserted mid-operation: all state returns to reset values on that edge, and priming restarts when reset is released.

Optional Feature:
- Macro: QDEC_X1_MODE_EN.
- Defined (x1 decoding):
  - step pulses only on 10->00 (up_down=1) and 00->10 (up_down=0).
  - Other legal transitions update prev only; they produce no step and leave up_down unchanged.
  - Illegal-transition handling is unchanged.
- Undefined (x4 decoding): every legal transition produces step, i.e. 4 counts per encoder cycle.

Test Plan (FILT_LEN=3, ERR_CNT_W=8 unless noted):
- Forward: after reset and priming, drive AB=00,01,11,10,00, each held 10 clocks -> 4 step pulses with up_down=1. The first pulse arrives 6 clocks after a_in/b_in first change is sampled.
- Reverse: from 00, drive 10,11,01,00 -> 4 step pulses with up_down=0. Downstream counter at 4'h0 reads 4'hC.
- Glitch: a_in high for 2 clocks then low -> no step, no err, filtered A stays 0. The same pulse held 4 clocks -> exactly one step.
- Illegal: from AB=00 switch both channels to 11 on the same clock -> err for exactly 1 clock, step=0, err_cnt 0->1, up_down unchanged. With ERR_CNT_W=2, 5 illegal events -> err_cnt=3.
- Enable and priming:
  - enable=0 during a forward transition 00->01 -> no step; re-enable then drive 01->11 -> exactly one step.
  - Release reset with a_in=b_in=1 -> no step or err.
- Reset mid-run: assert reset for 1 clock during a forward sequence -> step=0, err_cnt=0, up_down=1 on the next cycle. Priming restarts, and no output pulses occur for the next 3 clocks.
